gate_delay_monitor: RTL



---
 rtl/gate_delay_monitor_if.sv | 28 ++
 rtl/gate_delay_monitor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/gate_delay_monitor_if.sv
// Bundles the stimulus, observed gate output and measurement results of gate_delay_monitor.
// master drives stimulus/k1/clr; slave is the monitor.
interface gate_delay_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             a1;
    logic             b1;
    logic             e0;
    logic             k1;
    logic             clr;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             timeout;
    logic [CNT_W-1:0] last_delay;
    logic [CNT_W-1:0] worst_rise;
    logic [CNT_W-1:0] worst_fall;

    modport master (
        output a1, b1, e0, k1, clr,
        input  busy, done, aborted, timeout, last_delay, worst_rise, worst_fall
    );

    modport slave (
        input  a1, b1, e0, k1, clr,
        output busy, done, aborted, timeout, last_delay, worst_rise, worst_fall
    );
endinterface

// File: rtl/gate_delay_monitor.sv
// Measures settle delay of k1 = e0 & b1 & ~a1 after each stimulus change; tracks last/worst delays.
// Define GATE_DELAY_MON_SYNC_EN to pass k1 through a 2-flop synchronizer (+2 cycles on every delay).
module gate_delay_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_delay_monitor_if.slave   mon
);
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       stim_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic [CNT_W-1:0] last_delay_q, last_delay_d;
    logic [CNT_W-1:0] worst_rise_q, worst_rise_d;
    logic [CNT_W-1:0] worst_fall_q, worst_fall_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic [2:0]       stim;
    logic             exp_k1;
    logic             k1_s;
    logic             chg;

    assign stim   = {mon.a1, mon.b1, mon.e0};
    assign exp_k1 = mon.e0 & mon.b1 & ~mon.a1;
    assign chg    = (stim != stim_q);

`ifdef GATE_DELAY_MON_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mon.k1;
            sync2_q <= sync1_q;
        end
    end

    assign k1_s = sync2_q;
`else
    assign k1_s = mon.k1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stim_q       <= stim;
            cnt_q        <= '0;
            target_q     <= 1'b0;
            last_delay_q <= '0;
            worst_rise_q <= '0;
            worst_fall_q <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            last_delay_q <= last_delay_d;
            worst_rise_q <= worst_rise_d;
            worst_fall_q <= worst_fall_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        last_delay_d = last_delay_q;
        worst_rise_d = worst_rise_q;
        worst_fall_d = worst_fall_q;
        timeout_d    = timeout_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        if (mon.clr) begin
            state_d      = IDLE;
            cnt_d        = '0;
            target_d     = 1'b0;
            last_delay_d = '0;
            worst_rise_d = '0;
            worst_fall_d = '0;
            timeout_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (chg && (exp_k1 != k1_s)) begin
                        state_d  = MEASURE;
                        cnt_d    = CNT_W'(1);
                        target_d = exp_k1;
                    end
                end
                MEASURE: begin
                    // A stimulus change wins over a same-edge match: the measurement is abandoned.
                    if (chg) begin
                        aborted_d = 1'b1;
                        if (exp_k1 != k1_s) begin
                            cnt_d    = CNT_W'(1);
                            target_d = exp_k1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (k1_s == target_q) begin
                        done_d       = 1'b1;
                        last_delay_d = cnt_q;
                        if (target_q) begin
                            worst_rise_d = (cnt_q > worst_rise_q) ? cnt_q : worst_rise_q;
                        end else begin
                            worst_fall_d = (cnt_q > worst_fall_q) ? cnt_q : worst_fall_q;
                        end
                        state_d = IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mon.busy       = (state_q == MEASURE);
    assign mon.done       = done_q;
    assign mon.aborted    = aborted_q;
    assign mon.timeout    = timeout_q;
    assign mon.last_delay = last_delay_q;
    assign mon.worst_rise = worst_rise_q;
    assign mon.worst_fall = worst_fall_q;
endmodule
